// File: rtl/tetris_pkg.sv
// Shared Tetris types and constants: cell colours, line-clear FSM states
// and the arrow-key scancodes used by the control FSM.
package tetris_pkg;

   localparam int unsigned COLOR_W_DEFAULT     = 4;
   localparam int unsigned EMPTY_COLOR_DEFAULT = 7;

   typedef logic [COLOR_W_DEFAULT-1:0] color_t;

   localparam color_t EMPTY_COLOR = color_t'(EMPTY_COLOR_DEFAULT);

   typedef enum logic [2:0] {
      IDLE,
      SCAN_RD,
      SCAN_CHK,
      COPY_RD,
      COPY_WR,
      NEXT_ROW,
      FILL,
      DONE
   } lc_state_t;

   // PS/2 set-2 extended scancodes for the arrow keys
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/tetris_line_clear.sv
// Line-clear engine: one bottom-to-top pass over the board SRAM that drops
// full rows, copies survivors down and fills vacated top rows with empty.
module tetris_line_clear
   import tetris_pkg::*;
#(
   parameter int unsigned BOARD_W     = 21,
   parameter int unsigned BOARD_H     = 41,
   parameter int unsigned X_W         = 5,
   parameter int unsigned Y_W         = 6,
   parameter int unsigned COLOR_W     = COLOR_W_DEFAULT,
   parameter int unsigned EMPTY_COLOR = EMPTY_COLOR_DEFAULT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(BOARD_H+1)-1:0]   rows_cleared,
   output logic [X_W-1:0]                 mem_x,
   output logic [Y_W-1:0]                 mem_y,
   output logic                           mem_re,
   output logic                           mem_we,
   output logic [COLOR_W-1:0]             mem_wdata,
   input  logic [COLOR_W-1:0]             mem_rdata
);

   localparam int unsigned CW = $clog2(BOARD_H+1);

   localparam logic signed [Y_W:0]   TOP_ROW = (Y_W+1)'(BOARD_H-1);
   localparam logic signed [Y_W:0]   Y_ONE   = (Y_W+1)'(1);
   localparam logic [X_W-1:0]        X_LAST  = X_W'(BOARD_W-1);
   localparam logic [X_W-1:0]        X_ONE   = X_W'(1);
   localparam logic [CW-1:0]         C_ONE   = CW'(1);
   localparam logic [COLOR_W-1:0]    EMPTY   = COLOR_W'(EMPTY_COLOR);

   lc_state_t             state, state_n;
   logic signed [Y_W:0]   src, src_n;
   logic signed [Y_W:0]   dst, dst_n;
   logic [X_W-1:0]        x, x_n;
   logic [CW-1:0]         clr, clr_n;
   logic                  kept, kept_n;
   logic [CW-1:0]         rows_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         src    <= '0;
         dst    <= '0;
         x      <= '0;
         clr    <= '0;
         kept   <= 1'b0;
         rows_q <= '0;
      end else begin
         state <= state_n;
         src   <= src_n;
         dst   <= dst_n;
         x     <= x_n;
         clr   <= clr_n;
         kept  <= kept_n;
         if (state == DONE)
            rows_q <= clr;
      end
   end

   // Pointers are exhausted when their sign bit is set (value -1).
   always_comb begin
      state_n = state;
      src_n   = src;
      dst_n   = dst;
      x_n     = x;
      clr_n   = clr;
      kept_n  = kept;
      case (state)
         IDLE: begin
            if (start) begin
               src_n   = TOP_ROW;
               dst_n   = TOP_ROW;
               x_n     = '0;
               clr_n   = '0;
               state_n = SCAN_RD;
            end
         end
         SCAN_RD: state_n = SCAN_CHK;
         SCAN_CHK: begin
            if (mem_rdata == EMPTY) begin
               kept_n  = 1'b1;
               x_n     = '0;
               state_n = (src != dst) ? COPY_RD : NEXT_ROW;
            end else if (x == X_LAST) begin
               kept_n  = 1'b0;
               clr_n   = clr + C_ONE;
               state_n = NEXT_ROW;
            end else begin
               x_n     = x + X_ONE;
               state_n = SCAN_RD;
            end
         end
         COPY_RD: state_n = COPY_WR;
         COPY_WR: begin
            if (x == X_LAST) begin
               state_n = NEXT_ROW;
            end else begin
               x_n     = x + X_ONE;
               state_n = COPY_RD;
            end
         end
         NEXT_ROW: begin
            src_n = src - Y_ONE;
            if (kept)
               dst_n = dst - Y_ONE;
            x_n = '0;
            if (!src_n[Y_W])
               state_n = SCAN_RD;
            else if (!dst_n[Y_W])
               state_n = FILL;
            else
               state_n = DONE;
         end
         FILL: begin
            if (x == X_LAST) begin
               x_n   = '0;
               dst_n = dst - Y_ONE;
               if (dst_n[Y_W])
                  state_n = DONE;
            end else begin
               x_n = x + X_ONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      done         = (state == DONE);
      rows_cleared = rows_q;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      mem_x        = '0;
      mem_y        = '0;
      mem_wdata    = '0;
      case (state)
         SCAN_RD, COPY_RD: begin
            mem_re = 1'b1;
            mem_x  = x;
            mem_y  = src[Y_W-1:0];
         end
         COPY_WR: begin
            mem_we    = 1'b1;
            mem_x     = x;
            mem_y     = dst[Y_W-1:0];
            mem_wdata = mem_rdata;
         end
         FILL: begin
            mem_we    = 1'b1;
            mem_x     = x;
            mem_y     = dst[Y_W-1:0];
            mem_wdata = EMPTY;
         end
         DONE: rows_cleared = clr;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tetris_line_clear.sv
// Scoreboarded bench for tetris_line_clear with a 1-cycle-latency board SRAM model.
module tb_tetris_line_clear;

   localparam int W  = 21;
   localparam int H  = 41;
   localparam int CW = $clog2(H+1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic [CW-1:0] rows_cleared;
   logic [4:0]    mem_x;
   logic [5:0]    mem_y;
   logic          mem_re;
   logic          mem_we;
   logic [3:0]    mem_wdata;
   logic [3:0]    mem_rdata = '0;

   tetris_line_clear #(
      .BOARD_W(W), .BOARD_H(H), .X_W(5), .Y_W(6), .COLOR_W(4), .EMPTY_COLOR(7)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .rows_cleared(rows_cleared), .mem_x(mem_x), .mem_y(mem_y),
      .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rows;
      int writes;
      int lat;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [3:0] mem  [0:H-1][0:W-1];
   logic [3:0] expb [0:H-1][0:W-1];
   int tests = 0, fails = 0;
   int wr_cnt = 0, y0_cnt = 0, viol = 0, cyc = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Board SRAM: registered read, write on the strobe edge
   always @(posedge clk) begin
      if (mem_re)
         mem_rdata <= mem[mem_y][mem_x];
      if (mem_we) begin
         mem[mem_y][mem_x] <= mem_wdata;
         wr_cnt = wr_cnt + 1;
         if (mem_y == 0)
            y0_cnt = y0_cnt + 1;
      end
   end

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      if (reset) begin
         if (prev_done)
            check("done_width", int'(done), 0);
         prev_done = done;
         if ((mem_re && mem_we) ||
             (!mem_re && !mem_we && (mem_x != 0 || mem_y != 0 || mem_wdata != 0)))
            viol++;
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rows_cleared", int'(rows_cleared), e.rows);
               if (e.writes >= 0) check("write_count", wr_cnt, e.writes);
               if (e.lat >= 0)    check("done_latency", cyc, e.lat);
            end
         end
         if (busy && !done) cyc++;
         else if (!busy)    cyc = 0;
      end else begin
         prev_done = 1'b0;
         cyc       = 0;
      end
   end

   task automatic fill_board(input logic [3:0] c);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            mem[y][x]  = c;
            expb[y][x] = 4'd7;
         end
   endtask

   task automatic set_row(input int y, input logic [3:0] c);
      for (int x = 0; x < W; x++) mem[y][x] = c;
   endtask

   task automatic check_board(input string name);
      int bad = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (mem[y][x] !== expb[y][x]) bad++;
      check(name, bad, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb.size() != 0 || busy) && n < 5000);
      if (n >= 5000) check("timeout", 1, 0);
   endtask

   task automatic run(input int rows, input int writes, input int lat);
      sb.push_back('{rows, writes, lat});
      wr_cnt = 0;
      y0_cnt = 0;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_idle();
   endtask

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b0;
      fill_board(4'd7);
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_strobes", int'({mem_re, mem_we}), 0);
      check("rst_addr", int'({mem_x, mem_y, mem_wdata}), 0);
      check("rst_rows", int'(rows_cleared), 0);
      reset = 1'b1;
      @(negedge clk);

      // Empty board, with a stray start pulse mid-pass
      sb.push_back('{0, 0, 123});
      wr_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check_board("empty_board");

      // Bottom row full
      fill_board(4'd7);
      set_row(40, 4'd3);
      run(1, 861, -1);
      check("fill_y0_writes", y0_cnt, 21);
      check_board("row40_board");
      check("rows_held", int'(rows_cleared), 1);

      // Rows 40 and 38 full, lone cell in row 39
      fill_board(4'd7);
      set_row(40, 4'd3);
      set_row(38, 4'd1);
      mem[39][5]  = 4'd2;
      expb[40][5] = 4'd2;
      run(2, 861, -1);
      check_board("two_rows_board");

      // Whole board full
      fill_board(4'd3);
      run(41, 861, -1);
      check_board("all_full_board");

      // Reset during the first copy write
      fill_board(4'd7);
      set_row(40, 4'd3);
      wr_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!mem_we && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reach_copy_wr", int'(n < 500), 1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_we", int'(mem_we), 0);
      check("abort_done", int'(done), 0);
      check("abort_rows", int'(rows_cleared), 0);
      reset = 1'b1;
      @(negedge clk);
      fill_board(4'd7);
      set_row(40, 4'd3);
      run(1, 861, -1);
      check_board("after_abort_board");

      // Start held high: one pass per IDLE visit
      fill_board(4'd7);
      sb.push_back('{0, 0, 123});
      sb.push_back('{0, 0, 123});
      wr_cnt = 0;
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 500);
      check("held_first_done", int'(done), 1);
      @(negedge clk);
      check("held_idle_gap", int'(busy), 0);
      @(negedge clk);
      check("held_restart", int'(busy), 1);
      start = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);
      check("no_third_pass", int'(busy), 0);

      check("strobe_rules", viol, 0);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
